cpu_peripheral_arbiter: RTL and testbench
=========================================

CPU_PERIPHERAL_ARBITER -- requirements
Module: cpu_peripheral_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of WAIT cycles without peripheral ready before the access is aborted (legal range 2..255).
REQ-002 SHALL have port clk_2x  in  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_valid/m1_valid  in  1 each  requester access request, level, held until ready seen.
REQ-005 SHALL have ports m0_address/m1_address  in  24 each  byte address.
REQ-006 SHALL have ports m0_wstrb/m1_wstrb  in  4 each  byte write strobes; 0 = read.
REQ-007 SHALL have ports m0_write_data/m1_write_data  in  32 each  write data.
REQ-008 SHALL have ports m0_ready/m1_ready  out  1 each  access complete.
REQ-009 SHALL have ports m0_read_data/m1_read_data  out  32 each  read data, valid while the matching ready is high.
REQ-010 SHALL have ports p_sel  out  4  one-hot peripheral select; p_strobe  out  1  one-cycle access start.
REQ-011 SHALL have ports p_address  out  22; p_wstrb  out  4; p_write_data  out  32  latched access fields.
REQ-012 SHALL have ports p_ready  in  4  per-peripheral completion; p_read_data  in  128  packed, peripheral n at bits [32n+31:32n].
REQ-013 SHALL have ports err_timeout  out  1  sticky timeout flag; err_clear  in  1  clears err_timeout.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-015 IDLE: with exactly one valid, SHALL grant that requester; with both valid, SHALL grant the requester not granted last (round-robin); no valid keeps IDLE.
REQ-016 On grant SHALL latch address, wstrb and write_data, decode p_sel = onehot(address[23:22]), drive p_address = address[21:0], and go to ISSUE.
REQ-017 ISSUE SHALL assert p_strobe for exactly one cycle and go to WAIT; p_sel, p_address, p_wstrb and p_write_data SHALL stay stable from ISSUE through RESPOND.
REQ-018 WAIT SHALL clear the timeout counter on entry and increment it each cycle in which p_ready[sel] is 0.
REQ-019 WAIT with p_ready[sel]=1 SHALL capture p_read_data[sel] and go to RESPOND; p_ready bits of unselected peripherals SHALL be ignored.
REQ-020 WAIT with counter == TIMEOUT-1 and p_ready[sel]=0 SHALL capture 32'hFFFFFFFF, set err_timeout, and go to RESPOND.
REQ-021 If p_ready[sel] and the timeout condition occur in the same cycle, ready SHALL win with no error.
REQ-022 RESPOND SHALL assert the granted requester's ready with captured read data, and hold it while that requester's valid stays high.
REQ-023 RESPOND SHALL return to IDLE, update last-grant and deassert ready in the cycle after the granted valid is sampled low.
REQ-024 If the granted valid drops before RESPOND, the access SHALL still complete; ready SHALL pulse one cycle, then IDLE.
REQ-025 The non-granted requester's ready SHALL be 0 at all times; its valid SHALL be held pending, never dropped.
REQ-026 Minimum latency: valid sampled in IDLE at cycle N, p_strobe at N+1, p_ready at N+2, ready at N+3.
REQ-027 err_timeout: set has priority over a simultaneous err_clear; otherwise err_clear zeroes it next cycle.
REQ-028 p_sel SHALL be 0 in IDLE; read data outputs SHALL be 0 when the matching ready is 0.

Reset
REQ-029 reset SHALL force IDLE, zero all outputs and the timeout counter, clear err_timeout, and set last-grant = m1 so m0 wins the first tie.
REQ-030 reset mid-access SHALL abandon the transaction without asserting any ready; p_sel and p_strobe SHALL be 0 on the next cycle.

Verification
REQ-031 m0 reads 0x400010, peripheral 1 returns 0xDEADBEEF at N+2 -> p_sel=4'b0010, p_address=0x000010, m0_ready=1 and m0_read_data=0xDEADBEEF at N+3.
REQ-032 m0 and m1 valid together twice after reset -> first grant m0, second grant m1, no ready overlap.
REQ-033 m1 writes wstrb=4'hF to 0xC00000 with p_ready never set, TIMEOUT=16 -> m1_ready after 16 WAIT cycles, read data 0xFFFFFFFF, err_timeout=1; err_clear -> 0.
REQ-034 p_ready[sel] on the final timeout cycle -> normal data returned, err_timeout stays 0.
REQ-035 reset asserted during WAIT -> no ready, p_sel=0, next request serviced normally with m0 winning a tie.

Source files
------------

// File: rtl/cpu_peripheral_arbiter.sv
// Two-requester, round-robin arbiter in front of four memory-mapped peripherals.
// One access is in flight at a time; a stalled peripheral is cut off after TIMEOUT wait cycles.
module cpu_peripheral_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk_2x,
    input  logic         reset,

    input  logic         m0_valid,
    input  logic [23:0]  m0_address,
    input  logic [3:0]   m0_wstrb,
    input  logic [31:0]  m0_write_data,
    output logic         m0_ready,
    output logic [31:0]  m0_read_data,

    input  logic         m1_valid,
    input  logic [23:0]  m1_address,
    input  logic [3:0]   m1_wstrb,
    input  logic [31:0]  m1_write_data,
    output logic         m1_ready,
    output logic [31:0]  m1_read_data,

    output logic [3:0]   p_sel,
    output logic         p_strobe,
    output logic [21:0]  p_address,
    output logic [3:0]   p_wstrb,
    output logic [31:0]  p_write_data,
    input  logic [3:0]   p_ready,
    input  logic [127:0] p_read_data,

    output logic         err_timeout,
    input  logic         err_clear
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        grant;        // 0 = m0, 1 = m1
    logic        last_grant;   // requester served most recently
    logic [1:0]  sel_idx;
    logic [7:0]  timeout_count;
    logic [31:0] capture_data;

    logic        any_valid;
    logic        pick_m1;
    logic        granted_valid;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;

    assign any_valid     = m0_valid | m1_valid;
    // On a tie the requester that was not served last wins.
    assign pick_m1       = m1_valid & (~m0_valid | ~last_grant);
    assign granted_valid = grant ? m1_valid : m0_valid;
    assign sel_ready     = p_ready[sel_idx];
    assign sel_rdata     = p_read_data[{sel_idx, 5'd0} +: 32];
    assign timeout_hit   = (timeout_count == TIMEOUT_LAST) & ~sel_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (sel_ready || timeout_hit) state_next = RESPOND;
            RESPOND: if (!granted_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_2x) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            sel_idx       <= 2'd0;
            p_address     <= 22'd0;
            p_wstrb       <= 4'd0;
            p_write_data  <= 32'd0;
            timeout_count <= 8'd0;
            capture_data  <= 32'd0;
            err_timeout   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant        <= pick_m1;
                        sel_idx      <= pick_m1 ? m1_address[23:22] : m0_address[23:22];
                        p_address    <= pick_m1 ? m1_address[21:0]  : m0_address[21:0];
                        p_wstrb      <= pick_m1 ? m1_wstrb          : m0_wstrb;
                        p_write_data <= pick_m1 ? m1_write_data     : m0_write_data;
                    end
                end
                ISSUE: timeout_count <= 8'd0;
                WAIT: begin
                    if (sel_ready) begin
                        capture_data <= sel_rdata;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                        if (timeout_hit) capture_data <= 32'hFFFF_FFFF;
                    end
                end
                RESPOND: if (!granted_valid) last_grant <= grant;
                default: ;
            endcase

            // A new timeout beats a simultaneous clear request.
            if (state == WAIT && timeout_hit) err_timeout <= 1'b1;
            else if (err_clear)               err_timeout <= 1'b0;
        end
    end

    assign p_strobe     = (state == ISSUE);
    assign p_sel        = (state == IDLE) ? 4'b0000 : (4'b0001 << sel_idx);
    assign m0_ready     = (state == RESPOND) & ~grant;
    assign m1_ready     = (state == RESPOND) &  grant;
    assign m0_read_data = m0_ready ? capture_data : 32'd0;
    assign m1_read_data = m1_ready ? capture_data : 32'd0;

endmodule

// File: tb/tb_cpu_peripheral_arbiter.sv
// Self-checking bench for cpu_peripheral_arbiter: scoreboard of expected responses plus a
// behavioural peripheral whose completion delay is set per scenario.
module tb_cpu_peripheral_arbiter;

    logic         clk_2x = 1'b0;
    logic         reset = 1'b1;
    logic         m0_valid = 1'b0, m1_valid = 1'b0;
    logic [23:0]  m0_address = '0, m1_address = '0;
    logic [3:0]   m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0]  m0_write_data = '0, m1_write_data = '0;
    logic         m0_ready, m1_ready;
    logic [31:0]  m0_read_data, m1_read_data;
    logic [3:0]   p_sel;
    logic         p_strobe;
    logic [21:0]  p_address;
    logic [3:0]   p_wstrb;
    logic [31:0]  p_write_data;
    logic [3:0]   p_ready = '0;
    logic [127:0] p_read_data = {4{32'h0BAD_0BAD}};
    logic         err_timeout;
    logic         err_clear = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    // Peripheral model controls
    int          resp_delay = 0;   // WAIT cycles before ready; -1 = never
    logic [31:0] resp_base = '0;
    logic        junk = 1'b0;      // drive unselected p_ready bits while waiting
    logic        pending = 1'b0;
    int          wait_cnt = 0;
    logic [1:0]  msel = '0;
    logic [23:0] maddr = '0;

    cpu_peripheral_arbiter #(.TIMEOUT(16)) dut (
        .clk_2x(clk_2x), .reset(reset),
        .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrb(m0_wstrb),
        .m0_write_data(m0_write_data), .m0_ready(m0_ready), .m0_read_data(m0_read_data),
        .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrb(m1_wstrb),
        .m1_write_data(m1_write_data), .m1_ready(m1_ready), .m1_read_data(m1_read_data),
        .p_sel(p_sel), .p_strobe(p_strobe), .p_address(p_address), .p_wstrb(p_wstrb),
        .p_write_data(p_write_data), .p_ready(p_ready), .p_read_data(p_read_data),
        .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk_2x = ~clk_2x;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] data_for(input logic [31:0] base, input logic [23:0] addr);
        return base ^ {8'h00, addr};
    endfunction

    always @(negedge clk_2x) begin
        if (reset) begin
            pending = 1'b0;
            p_ready = 4'b0000;
        end else if (p_strobe) begin
            for (int k = 0; k < 4; k++) if (p_sel[k]) msel = k[1:0];
            maddr    = {msel, p_address};
            pending  = 1'b1;
            wait_cnt = 0;
            p_ready  = 4'b0000;
        end else if (pending) begin
            if (resp_delay >= 0 && wait_cnt == resp_delay) begin
                p_ready = 4'b0001 << msel;
                p_read_data[msel*32 +: 32] = data_for(resp_base, maddr);
                pending = 1'b0;
            end else begin
                wait_cnt++;
                p_ready = junk ? ~(4'b0001 << msel) : 4'b0000;
            end
        end else begin
            p_ready = 4'b0000;
        end
    end

    task automatic send(input logic who, input logic [23:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        if (who) begin
            m1_valid = 1'b1; m1_address = addr; m1_wstrb = wstrb; m1_write_data = wdata;
        end else begin
            m0_valid = 1'b1; m0_address = addr; m0_wstrb = wstrb; m0_write_data = wdata;
        end
        e.who = who; e.data = exp_data; e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // Services readies against the scoreboard until the queue drains and the DUT is idle.
    // Each requester drops valid after holding it 'hold' extra cycles past its first ready.
    task automatic run_until_idle(input int max_cycles, input int hold,
                                  output int first_ready, output int ready_cycles);
        int          age [2];
        logic [31:0] cur [2];
        logic        rdy [2];
        logic [31:0] rd [2];
        exp_t        e;
        age[0] = 0; age[1] = 0; cur[0] = '0; cur[1] = '0;
        first_ready = -1;
        ready_cycles = 0;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk_2x);
            rdy[0] = m0_ready; rdy[1] = m1_ready;
            rd[0] = m0_read_data; rd[1] = m1_read_data;
            if (m0_ready || m1_ready) begin
                checks++;
                if (m0_ready && m1_ready) begin
                    errors++;
                    $display("FAIL ready_overlap: m0_ready=%b m1_ready=%b, required not both", m0_ready, m1_ready);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rdy[i]) begin
                    ready_cycles++;
                    if (first_ready < 0) first_ready = c;
                    if (age[i] == 0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_ready: m%0d ready with data %h, no response expected", i, rd[i]);
                            cur[i] = rd[i];
                        end else begin
                            e = exp_q.pop_front();
                            cur[i] = e.data;
                            if (e.who !== i[0] || rd[i] !== e.data || err_timeout !== e.err) begin
                                errors++;
                                $display("FAIL response: got m%0d data=%h err=%b, required m%0d data=%h err=%b",
                                         i, rd[i], err_timeout, e.who, e.data, e.err);
                            end
                        end
                    end else begin
                        checks++;
                        if (rd[i] !== cur[i]) begin
                            errors++;
                            $display("FAIL hold_data: m%0d data=%h, required %h", i, rd[i], cur[i]);
                        end
                    end
                    if (age[i] >= hold) begin
                        if (i == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
                    end
                    age[i]++;
                end else begin
                    age[i] = 0;
                    checks++;
                    if (rd[i] !== 32'd0) begin
                        errors++;
                        $display("FAIL idle_read_data: m%0d data=%h while not ready, required 0", i, rd[i]);
                    end
                end
            end
            if (exp_q.size() == 0 && !m0_ready && !m1_ready && p_sel == 4'b0000) return;
        end
        checks++;
        errors++;
        $display("FAIL run_timeout: %0d responses still outstanding after %0d cycles", exp_q.size(), max_cycles);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge clk_2x);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (p_sel !== 4'b0 || p_strobe !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: p_sel=%b p_strobe=%b m0_ready=%b m1_ready=%b, required all 0",
                     p_sel, p_strobe, m0_ready, m1_ready);
        end
        checks++;
        if (p_address !== 22'd0 || p_wstrb !== 4'd0 || p_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_fields: p_address=%h p_wstrb=%h p_write_data=%h, required 0",
                     p_address, p_wstrb, p_write_data);
        end
        checks++;
        if (m0_read_data !== 32'd0 || m1_read_data !== 32'd0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: m0_rd=%h m1_rd=%h err=%b, required 0", m0_read_data, m1_read_data, err_timeout);
        end
    endtask

    task automatic test_min_latency();
        int fr, rc;
        resp_delay = 0;
        junk = 1'b0;
        resp_base = 32'hDEAD_BEEF ^ 32'h0040_0010;
        send(1'b0, 24'h400010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk_2x);
        checks++;
        if (p_strobe !== 1'b1 || p_sel !== 4'b0010 || p_address !== 22'h000010 || p_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL issue_fields: strobe=%b sel=%b addr=%h wstrb=%h, required 1 0010 000010 0",
                     p_strobe, p_sel, p_address, p_wstrb);
        end
        @(negedge clk_2x);
        checks++;
        if (p_strobe !== 1'b0 || p_sel !== 4'b0010 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle: strobe=%b sel=%b m0_ready=%b, required 0 0010 0", p_strobe, p_sel, m0_ready);
        end
        run_until_idle(20, 0, fr, rc);
        checks++;
        if (fr !== 1) begin
            errors++;
            $display("FAIL min_latency: ready one cycle after WAIT at offset %0d, required 1", fr);
        end
    endtask

    task automatic test_round_robin();
        int fr, rc;
        do_reset();
        resp_delay = 2;
        resp_base = 32'h1357_9BDF;
        send(1'b0, 24'h000004, 4'h0, 32'h0, data_for(32'h1357_9BDF, 24'h000004), 1'b0);
        send(1'b1, 24'h800008, 4'h0, 32'h0, data_for(32'h1357_9BDF, 24'h800008), 1'b0);
        run_until_idle(60, 0, fr, rc);
        // m0 served alone, so a fresh tie must go to m1.
        send(1'b0, 24'h40000C, 4'h0, 32'h0, data_for(32'h1357_9BDF, 24'h40000C), 1'b0);
        run_until_idle(30, 0, fr, rc);
        send(1'b1, 24'hC00014, 4'h0, 32'h0, data_for(32'h1357_9BDF, 24'hC00014), 1'b0);
        send(1'b0, 24'h000018, 4'h0, 32'h0, data_for(32'h1357_9BDF, 24'h000018), 1'b0);
        run_until_idle(60, 0, fr, rc);
    endtask

    task automatic test_timeout();
        int fr, rc;
        resp_delay = -1;
        send(1'b1, 24'hC00000, 4'hF, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk_2x);
        checks++;
        if (p_sel !== 4'b1000 || p_address !== 22'd0 || p_wstrb !== 4'hF || p_write_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_fields: sel=%b addr=%h wstrb=%h wdata=%h, required 1000 0 F 12345678",
                     p_sel, p_address, p_wstrb, p_write_data);
        end
        run_until_idle(40, 0, fr, rc);
        checks++;
        if (fr !== 17) begin
            errors++;
            $display("FAIL timeout_latency: ready at offset %0d, required 17 (16 WAIT cycles)", fr);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err_timeout=%b, required 1", err_timeout);
        end
        err_clear = 1'b1;
        @(negedge clk_2x);
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err_timeout=%b, required 0", err_timeout);
        end
    endtask

    task automatic test_set_beats_clear();
        int fr, rc;
        resp_delay = -1;
        junk = 1'b1;
        err_clear = 1'b1;
        send(1'b0, 24'h400020, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
        run_until_idle(40, 0, fr, rc);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_after: err_timeout=%b, required 0", err_timeout);
        end
        err_clear = 1'b0;
        junk = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        int fr, rc;
        resp_delay = 15;
        resp_base = 32'hA5A5_0F0F;
        send(1'b0, 24'h800030, 4'h0, 32'h0, data_for(32'hA5A5_0F0F, 24'h800030), 1'b0);
        run_until_idle(40, 0, fr, rc);
        checks++;
        if (fr !== 18 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary: ready offset %0d err=%b, required 18 and 0", fr, err_timeout);
        end
    endtask

    task automatic test_hold_and_drop();
        int fr, rc;
        resp_delay = 1;
        resp_base = 32'h0F1E_2D3C;
        send(1'b1, 24'h40000C, 4'h0, 32'h0, data_for(32'h0F1E_2D3C, 24'h40000C), 1'b0);
        run_until_idle(30, 3, fr, rc);
        checks++;
        if (rc !== 4) begin
            errors++;
            $display("FAIL hold_ready: ready high %0d cycles, required 4", rc);
        end
        resp_delay = 3;
        send(1'b1, 24'hC00040, 4'h3, 32'hCAFE_F00D, data_for(32'h0F1E_2D3C, 24'hC00040), 1'b0);
        @(negedge clk_2x);
        m1_valid = 1'b0;
        run_until_idle(30, 0, fr, rc);
        checks++;
        if (rc !== 1) begin
            errors++;
            $display("FAIL early_drop: ready high %0d cycles, required 1", rc);
        end
    endtask

    task automatic test_reset_mid_access();
        int   fr, rc;
        logic seen;
        resp_delay = -1;
        m0_valid = 1'b1; m0_address = 24'h400044; m0_wstrb = 4'h0;
        repeat (5) @(negedge clk_2x);
        reset = 1'b1;
        @(negedge clk_2x);
        checks++;
        if (p_sel !== 4'b0 || p_strobe !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: sel=%b strobe=%b m0_ready=%b m1_ready=%b, required all 0",
                     p_sel, p_strobe, m0_ready, m1_ready);
        end
        reset = 1'b0;
        m0_valid = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_2x);
            if (m0_ready || m1_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_ready: ready seen=%b after reset, required 0", seen);
        end
        resp_delay = 0;
        resp_base = 32'h2468_ACE0;
        send(1'b0, 24'h000050, 4'h0, 32'h0, data_for(32'h2468_ACE0, 24'h000050), 1'b0);
        send(1'b1, 24'h800054, 4'h0, 32'h0, data_for(32'h2468_ACE0, 24'h800054), 1'b0);
        run_until_idle(40, 0, fr, rc);
    endtask

    initial begin
        @(negedge clk_2x);
        test_reset();
        test_min_latency();
        test_round_robin();
        test_timeout();
        test_set_beats_clear();
        test_timeout_boundary();
        test_hold_and_drop();
        test_reset_mid_access();
        repeat (2) @(negedge clk_2x);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
